// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path (uart_axis_rx, axis_byte_fifo).
package uart_rx_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/axis_byte_fifo.sv
// First-word-fall-through byte FIFO driving an AXI-Stream master port.
module axis_byte_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              wr_rdy_o,
  output logic [BYTE_W-1:0] tdata_o,
  output logic              tvalid_o,
  input  logic              tready_i
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                   wr_q, rd_q;
  logic [DEPTH-1:0][BYTE_W-1:0] mem_q;
  logic                          empty, full, pop, we;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && tready_i;
  // A pop on the same edge frees a slot, so a full FIFO can still take the byte.
  assign wr_rdy_o = !full || pop;
  assign we       = push_i && wr_rdy_o;
  assign tvalid_o = !empty;
  assign tdata_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      if (we) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/uart_axis_rx.sv
// 8N1 UART receiver feeding an AXI-Stream byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_axis_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              rxd,
  output logic [BYTE_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF = CPB / 2;
  localparam int TW   = $clog2(CPB);
  localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);
  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);

  logic [1:0]        sync_q;
  logic              rxd_s;
  rx_state_t         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              ferr_q, ferr_d, ovr_q, ovr_d;
  logic              push, wr_rdy;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign rxd_s = sync_q[1];

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rxd_s) state_d = START;
      end
      START: if (timer_q == T_HALF) begin
        timer_d = '0;
        bit_d   = '0;
        state_d = rxd_s ? IDLE : DATA;
      end
      DATA: if (timer_q == T_LAST) begin
        timer_d = '0;
        shift_d = {rxd_s, shift_q[BYTE_W-1:1]};
        bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_q == 3'd7) state_d = PARITY;
`else
        if (bit_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (timer_q == T_LAST) begin
        timer_d = '0;
        par_d   = rxd_s ^ (^shift_q);
        state_d = STOP;
      end
`endif
      STOP: if (timer_q == T_LAST) begin
        timer_d = '0;
`ifdef UART_RX_PARITY_EN
        if (par_q) begin
          ferr_d  = 1'b1;
          state_d = rxd_s ? IDLE : WAIT_HIGH;
        end else
`endif
        if (rxd_s) begin
          push    = wr_rdy;
          ovr_d   = !wr_rdy;
          state_d = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = WAIT_HIGH;
        end
      end
      // A held-low line (break) must not decode as a stream of 0x00 bytes.
      WAIT_HIGH: begin
        timer_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

  axis_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i    (clk),
    .arst_i   (arst),
    .push_i   (push),
    .data_i   (shift_q),
    .wr_rdy_o (wr_rdy),
    .tdata_o  (m_axis_tdata),
    .tvalid_o (m_axis_tvalid),
    .tready_i (m_axis_tready)
  );
endmodule

// File: tb/tb_uart_axis_rx.sv
// Directed + random bench for uart_axis_rx against a queue-based byte-stream model.
module tb_uart_axis_rx;
  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic       clk = 1'b0, arst = 1'b1, rxd = 1'b1, tready = 1'b0;
  logic [7:0] tdata;
  logic       tvalid, ferr, ovr;

  always #5 clk = ~clk;

  uart_axis_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .arst(arst), .rxd(rxd),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .frame_err(ferr), .overrun(ovr)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, t_start = 0, first_vld = -1;
  int n_ferr = 0, n_ovr = 0, n_both = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    #1;
    if (tvalid && tready) got.push_back(tdata);
    if (ferr) n_ferr++;
    if (ovr) n_ovr++;
    if (ferr && ovr) n_both++;
    if (tvalid && first_vld < 0) first_vld = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) chk($sformatf("%s_beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic clear();
    got.delete(); exp_q.delete();
    n_ferr = 0; n_ovr = 0; first_vld = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pb, input logic stop);
    @(negedge clk);
    rxd = 1'b0; t_start = cyc;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin rxd = d[i]; idle(CPB); end
    if (NPAR != 0) begin rxd = pb; idle(CPB); end
    rxd = stop; idle(CPB);
  endtask

  task automatic send_ok(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    int occ, exp_ovr;

    idle(3); #1;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_ovr", 32'(ovr), 0);
    @(negedge clk); arst = 1'b0; idle(5);

    // Single byte, latency from start-bit edge to tvalid.
    tready = 1'b1; clear();
    send_ok(8'hC0); idle(5);
    exp_q.push_back(8'hC0); cmp_q("single");
    chk("latency", first_vld - t_start, 3 + HALF + (9 + NPAR) * CPB);
    chk("single_ferr", n_ferr, 0);

    clear();
    foreach (exp_q[i]) ;
    exp_q = '{8'hC0, 8'h88, 8'h43, 8'hA8};
    for (int i = 0; i < 4; i++) send_ok(exp_q[i]);
    idle(5);
    cmp_q("b2b");
    chk("b2b_ferr", n_ferr, 0);
    chk("b2b_ovr", n_ovr, 0);

    clear();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      idle($urandom_range(0, 3));
      send_ok(b);
      exp_q.push_back(b);
    end
    idle(5);
    cmp_q("rand");

    // Back-pressure: model FIFO occupancy, bytes beyond DEPTH are lost.
    tready = 1'b0; clear(); occ = 0; exp_ovr = 0;
    for (int i = 1; i <= 6; i++) begin
      send_ok(8'(i));
      if (occ < DEPTH) begin occ++; exp_q.push_back(8'(i)); end
      else exp_ovr++;
      if (i == DEPTH) chk("ovr_before_full", n_ovr, 0);
    end
    idle(3);
    chk("ovr_count", n_ovr, exp_ovr);
    chk("stall_tvalid", 32'(tvalid), 1);
    chk("stall_tdata", 32'(tdata), 32'(exp_q[0]));
    tready = 1'b1; idle(DEPTH + 3);
    cmp_q("drain");
    chk("drain_tvalid", 32'(tvalid), 0);

    // Short low glitch must be ignored.
    clear();
    @(negedge clk); rxd = 1'b0; idle(3); rxd = 1'b1; idle(2 * CPB);
    chk("glitch_beats", got.size(), 0);
    chk("glitch_ferr", n_ferr, 0);
    send_ok(8'h5A); idle(5);
    exp_q.push_back(8'h5A); cmp_q("post_glitch");

    // Bad stop bit followed by a break.
    clear();
    send_frame(8'h55, ^8'h55, 1'b0);
    idle(30); rxd = 1'b1; idle(CPB);
    send_ok(8'h3C); idle(5);
    chk("break_ferr", n_ferr, 1);
    chk("break_ovr", n_ovr, 0);
    exp_q.push_back(8'h3C); cmp_q("break");

    // Reset mid-byte with a byte buffered.
    tready = 1'b0; clear();
    send_ok(8'h11); idle(3);
    chk("held_tdata", 32'(tdata), 32'h11);
    @(negedge clk); rxd = 1'b0; idle(CPB);
    for (int i = 0; i < 4; i++) begin rxd = 1'b1; idle(CPB); end
    idle(HALF);
    #1 arst = 1'b1;
    #1;
    chk("arst_tvalid", 32'(tvalid), 0);
    chk("arst_tdata", 32'(tdata), 0);
    idle(2); rxd = 1'b1; arst = 1'b0; tready = 1'b1;
    got.delete(); idle(5);
    send_ok(8'h22); idle(5);
    exp_q.push_back(8'h22); cmp_q("after_rst");

`ifdef UART_RX_PARITY_EN
    clear();
    send_frame(8'h07, 1'b0, 1'b1); idle(5);
    chk("par_bad_ferr", n_ferr, 1);
    chk("par_bad_beats", got.size(), 0);
    send_frame(8'h07, 1'b1, 1'b1); idle(5);
    exp_q.push_back(8'h07); cmp_q("par_good");
    chk("par_good_ferr", n_ferr, 1);
`endif

    chk("no_dual_pulse", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
